// File: rtl/game_pkg.sv
// Shared encodings for the two-player quiz round arbiter: FSM states,
// per-player judgement codes and game winner codes.
package game_pkg;

  localparam int TIMER_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAITQ    = 3'd2,
    ST_ANSWER   = 3'd3,
    ST_JUDGE    = 3'd4,
    ST_GAP      = 3'd5,
    ST_GAMEOVER = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    JUDG_NONE = 2'b00,
    JUDG_SELF = 2'b01,
    JUDG_OPP  = 2'b10,
    JUDG_VOID = 2'b11
  } judg_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  // The player whose HP is exhausted loses; both exhausted is a draw.
  function automatic winner_e winner_from_hp(input logic hp1_zero, input logic hp2_zero);
    winner_e w;
    case ({hp1_zero, hp2_zero})
      2'b10:   w = WIN_P2;
      2'b01:   w = WIN_P1;
      2'b11:   w = WIN_DRAW;
      default: w = WIN_NONE;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/answer_arb.sv
// Per-round answer arbitration: wrong-answer lockout, same-cycle tie-break
// (alternating priority after scored rounds) and the resulting judgement codes.
module answer_arb
  import game_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  active_i,
  input  logic  clear_i,
  input  logic  p1_valid_i,
  input  logic  p1_ok_i,
  input  logic  p2_valid_i,
  input  logic  p2_ok_i,
  output logic  decide_o,
  output judg_e judg1_o,
  output judg_e judg2_o,
  output logic  wrong1_o,
  output logic  wrong2_o
);

  logic lock1_q, lock1_d;
  logic lock2_q, lock2_d;
  logic prio_p2_q, prio_p2_d;
  logic wrong1_q, wrong2_q;
  logic ok1, ok2, bad1, bad2;
  logic win1, win2;

  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    ok1  = active_i & p1_valid_i & ~lock1_q &  p1_ok_i;
    bad1 = active_i & p1_valid_i & ~lock1_q & ~p1_ok_i;
    ok2  = active_i & p2_valid_i & ~lock2_q &  p2_ok_i;
    bad2 = active_i & p2_valid_i & ~lock2_q & ~p2_ok_i;

    // A simultaneous double-correct goes to whoever did not win the last scored round.
    win1 = ok1 & (~ok2 | ~prio_p2_q);
    win2 = ok2 & (~ok1 |  prio_p2_q);

    lock1_d   = clear_i ? 1'b0 : (lock1_q | bad1);
    lock2_d   = clear_i ? 1'b0 : (lock2_q | bad2);
    prio_p2_d = (win1 | win2) ? win1 : prio_p2_q;

    decide_o = active_i & (win1 | win2 | (lock1_d & lock2_d));

    judg1_o = JUDG_VOID;
    judg2_o = JUDG_VOID;
    if (win1) begin
      judg1_o = JUDG_SELF;
      judg2_o = JUDG_OPP;
    end else if (win2) begin
      judg1_o = JUDG_OPP;
      judg2_o = JUDG_SELF;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      lock1_q   <= 1'b0;
      lock2_q   <= 1'b0;
      prio_p2_q <= 1'b0;
      wrong1_q  <= 1'b0;
      wrong2_q  <= 1'b0;
    end else begin
      lock1_q   <= lock1_d;
      lock2_q   <= lock2_d;
      prio_p2_q <= prio_p2_d;
      wrong1_q  <= bad1;
      wrong2_q  <= bad2;
    end
  end

  assign wrong1_o = wrong1_q;
  assign wrong2_o = wrong2_q;

endmodule

// File: rtl/round_arbiter.sv
// Round sequencing for a two-player factorization duel: requests problems,
// times the answer window and cooldown, reports per-round judgements and the winner.
module round_arbiter
  import game_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000,
  parameter int GAP_CYC     = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       READY_IN,
  input  logic       QUE_RDY,
  input  logic       P1_VALID,
  input  logic       P2_VALID,
  input  logic       P1_OK,
  input  logic       P2_OK,
  input  logic       HP1_ZERO,
  input  logic       HP2_ZERO,
  output logic       QUE_REQ,
  output logic       QUE,
  output logic [1:0] JUDG1,
  output logic [1:0] JUDG2,
  output logic       WRONG1,
  output logic       WRONG2,
  output logic [2:0] STATE,
  output logic [1:0] WINNER
);

  localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD     = TIMER_W'(GAP_CYC - 1);

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  judg_e                judg1_q, judg1_d;
  judg_e                judg2_q, judg2_d;
  winner_e              winner_q, winner_d;

  logic  timer_zero;
  logic  arb_active, arb_clear, arb_decide;
  logic  arb_wrong1, arb_wrong2;
  judg_e arb_judg1, arb_judg2;

  assign timer_zero = (timer_q == '0);
  assign arb_active = (state_q == ST_ANSWER) && READY_IN;
  assign arb_clear  = (state_q != ST_ANSWER);

  answer_arb u_answer_arb (
    .clk        (CLK),
    .rst        (RST),
    .active_i   (arb_active),
    .clear_i    (arb_clear),
    .p1_valid_i (P1_VALID),
    .p1_ok_i    (P1_OK),
    .p2_valid_i (P2_VALID),
    .p2_ok_i    (P2_OK),
    .decide_o   (arb_decide),
    .judg1_o    (arb_judg1),
    .judg2_o    (arb_judg2),
    .wrong1_o   (arb_wrong1),
    .wrong2_o   (arb_wrong2)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      judg1_q  <= JUDG_NONE;
      judg2_q  <= JUDG_NONE;
      winner_q <= WIN_NONE;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      judg1_q  <= judg1_d;
      judg2_q  <= judg2_d;
      winner_q <= winner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (READY_IN) state_d = ST_REQ;
      ST_REQ:      state_d = ST_WAITQ;
      ST_WAITQ:    if (QUE_RDY) state_d = ST_ANSWER;
      ST_ANSWER:   if (arb_decide || timer_zero) state_d = ST_JUDGE;
      ST_JUDGE:    state_d = ST_GAP;
      ST_GAP:      if (timer_zero) state_d = (HP1_ZERO || HP2_ZERO) ? ST_GAMEOVER : ST_REQ;
      ST_GAMEOVER: if (!READY_IN) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    // Losing readiness abandons the game from anywhere short of a finished one.
    if (!READY_IN && state_q != ST_GAMEOVER) state_d = ST_IDLE;
  end

  always_comb begin
    timer_d  = timer_q;
    judg1_d  = JUDG_NONE;
    judg2_d  = JUDG_NONE;
    winner_d = WIN_NONE;

    if (state_q == ST_WAITQ && state_d == ST_ANSWER) begin
      timer_d = TIMEOUT_LOAD;
    end else if (state_q == ST_JUDGE && state_d == ST_GAP) begin
      timer_d = GAP_LOAD;
    end else if ((state_q == ST_ANSWER || state_q == ST_GAP) && !timer_zero) begin
      timer_d = timer_q - TIMER_W'(1);
    end

    // With no winner the arbiter reports void codes, which also covers the timeout.
    if (state_q == ST_ANSWER && state_d == ST_JUDGE) begin
      judg1_d = arb_judg1;
      judg2_d = arb_judg2;
    end

    if (state_d == ST_GAMEOVER) begin
      winner_d = (state_q == ST_GAMEOVER) ? winner_q : winner_from_hp(HP1_ZERO, HP2_ZERO);
    end
  end

  always_comb begin
    STATE   = state_q;
    QUE_REQ = (state_q == ST_REQ);
    QUE     = (state_q == ST_ANSWER);
    JUDG1   = judg1_q;
    JUDG2   = judg2_q;
    WRONG1  = arb_wrong1;
    WRONG2  = arb_wrong2;
    WINNER  = winner_q;
  end

endmodule

// File: tb/tb_round_arbiter.sv
// Bench for round_arbiter: two instances (long and short answer window) share
// directed stimulus; a per-cycle reference model plus literal expectations check them.
module tb_round_arbiter;

  localparam int TMO_A = 20;
  localparam int GAP_A = 4;
  localparam int TMO_B = 8;
  localparam int GAP_B = 4;

  localparam int S_IDLE = 0, S_REQ = 1, S_WAITQ = 2, S_ANSWER = 3;
  localparam int S_JUDGE = 4, S_GAP = 5, S_OVER = 6;

  logic clk = 1'b0;
  logic rst, ready, que_rdy, p1v, p1ok, p2v, p2ok, hp1, hp2;

  logic       que_req_w [2];
  logic       que_w     [2];
  logic [1:0] judg1_w   [2];
  logic [1:0] judg2_w   [2];
  logic       wrong1_w  [2];
  logic       wrong2_w  [2];
  logic [2:0] state_w   [2];
  logic [1:0] winner_w  [2];

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  round_arbiter #(.TIMEOUT_CYC(TMO_A), .GAP_CYC(GAP_A)) dut_a (
    .CLK(clk), .RST(rst), .READY_IN(ready), .QUE_RDY(que_rdy),
    .P1_VALID(p1v), .P2_VALID(p2v), .P1_OK(p1ok), .P2_OK(p2ok),
    .HP1_ZERO(hp1), .HP2_ZERO(hp2),
    .QUE_REQ(que_req_w[0]), .QUE(que_w[0]), .JUDG1(judg1_w[0]), .JUDG2(judg2_w[0]),
    .WRONG1(wrong1_w[0]), .WRONG2(wrong2_w[0]), .STATE(state_w[0]), .WINNER(winner_w[0])
  );

  round_arbiter #(.TIMEOUT_CYC(TMO_B), .GAP_CYC(GAP_B)) dut_b (
    .CLK(clk), .RST(rst), .READY_IN(ready), .QUE_RDY(que_rdy),
    .P1_VALID(p1v), .P2_VALID(p2v), .P1_OK(p1ok), .P2_OK(p2ok),
    .HP1_ZERO(hp1), .HP2_ZERO(hp2),
    .QUE_REQ(que_req_w[1]), .QUE(que_w[1]), .JUDG1(judg1_w[1]), .JUDG2(judg2_w[1]),
    .WRONG1(wrong1_w[1]), .WRONG2(wrong2_w[1]), .STATE(state_w[1]), .WINNER(winner_w[1])
  );

  // Reference model: phase number, cycles spent in the phase, who is locked out,
  // who won the last scored round, and the pulses/codes due in the current cycle.
  typedef struct {
    int         st;
    int         elapsed;
    bit         lock1;
    bit         lock2;
    int         last_win;
    logic [1:0] j1;
    logic [1:0] j2;
    bit         w1;
    bit         w2;
    logic [1:0] win;
  } model_t;

  model_t mdl [2];

  function automatic model_t step(input model_t m_in, input bit r, rdy, qr, v1, k1, v2, k2,
                                  h1, h2, input int tmo, input int gp);
    model_t m;
    bit c1, c2, b1, b2;
    int w;
    m = m_in;
    m.j1 = 2'b00; m.j2 = 2'b00; m.w1 = 1'b0; m.w2 = 1'b0;
    if (r) begin
      m.st = S_IDLE; m.elapsed = 0; m.lock1 = 1'b0; m.lock2 = 1'b0;
      m.last_win = 0; m.win = 2'b00;
    end else if (!rdy && m.st != S_OVER) begin
      m.st = S_IDLE;
    end else begin
      case (m.st)
        S_IDLE:  if (rdy) m.st = S_REQ;
        S_REQ:   m.st = S_WAITQ;
        S_WAITQ: if (qr) begin
          m.st = S_ANSWER; m.elapsed = 0; m.lock1 = 1'b0; m.lock2 = 1'b0;
        end
        S_ANSWER: begin
          m.elapsed++;
          c1 = v1 && !m.lock1 && k1;
          b1 = v1 && !m.lock1 && !k1;
          c2 = v2 && !m.lock2 && k2;
          b2 = v2 && !m.lock2 && !k2;
          m.w1 = b1; m.w2 = b2;
          if (b1) m.lock1 = 1'b1;
          if (b2) m.lock2 = 1'b1;
          w = 0;
          if (c1 && c2)  w = (m.last_win == 1) ? 2 : 1;
          else if (c1)   w = 1;
          else if (c2)   w = 2;
          if (w == 1) begin
            m.j1 = 2'b01; m.j2 = 2'b10; m.last_win = 1; m.st = S_JUDGE;
          end else if (w == 2) begin
            m.j1 = 2'b10; m.j2 = 2'b01; m.last_win = 2; m.st = S_JUDGE;
          end else if ((m.lock1 && m.lock2) || m.elapsed == tmo) begin
            m.j1 = 2'b11; m.j2 = 2'b11; m.st = S_JUDGE;
          end
        end
        S_JUDGE: begin m.st = S_GAP; m.elapsed = 0; end
        S_GAP: begin
          m.elapsed++;
          if (m.elapsed == gp) begin
            if (h1 && h2)  begin m.st = S_OVER; m.win = 2'b11; end
            else if (h1)   begin m.st = S_OVER; m.win = 2'b10; end
            else if (h2)   begin m.st = S_OVER; m.win = 2'b01; end
            else           m.st = S_REQ;
          end
        end
        S_OVER:  if (!rdy) m.st = S_IDLE;
        default: m.st = S_IDLE;
      endcase
    end
    return m;
  endfunction

  function automatic logic [15:0] exp_out(input model_t m);
    logic [2:0] s;
    s = 3'(m.st);
    return {3'b000, s, (m.st == S_REQ), (m.st == S_ANSWER), m.j1, m.j2, m.w1, m.w2,
            (m.st == S_OVER) ? m.win : 2'b00};
  endfunction

  function automatic logic [15:0] dut_out(input int i);
    return {3'b000, state_w[i], que_req_w[i], que_w[i], judg1_w[i], judg2_w[i],
            wrong1_w[i], wrong2_w[i], winner_w[i]};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    mdl[0] <= step(mdl[0], rst, ready, que_rdy, p1v, p1ok, p2v, p2ok, hp1, hp2, TMO_A, GAP_A);
    mdl[1] <= step(mdl[1], rst, ready, que_rdy, p1v, p1ok, p2v, p2ok, hp1, hp2, TMO_B, GAP_B);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) check($sformatf("cycle_dut%0d", i), dut_out(i), exp_out(mdl[i]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int i, input int target, input int budget);
    int n;
    n = 0;
    while (state_w[i] != 3'(target) && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("wait_state_%0d_dut%0d", target, i), {13'd0, state_w[i]}, 16'(target));
  endtask

  // Leaves both instances in their first ANSWER cycle, QUE_RDY three cycles after QUE_REQ.
  task automatic start_round();
    ready = 1'b1;
    wait_state(0, S_REQ, 20);
    repeat (3) tick();
    que_rdy = 1'b1;
    tick();
    que_rdy = 1'b0;
  endtask

  task automatic clear_answers();
    p1v = 1'b0; p1ok = 1'b0; p2v = 1'b0; p2ok = 1'b0;
  endtask

  task automatic abort_to_idle();
    ready = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    rst = 1'b1; ready = 1'b0; que_rdy = 1'b0; hp1 = 1'b0; hp2 = 1'b0;
    clear_answers();
    repeat (2) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_dut0", dut_out(0), 16'h0000);
    check("reset_dut1", dut_out(1), 16'h0000);

    // Winner in ANSWER cycle 10 of the long-window instance.
    ready = 1'b1;
    tick();
    check("s1_que_req", {15'd0, que_req_w[0]}, 16'd1);
    repeat (3) tick();
    que_rdy = 1'b1;
    tick();
    que_rdy = 1'b0;
    check("s1_que_open", {15'd0, que_w[0]}, 16'd1);
    repeat (9) tick();
    p1v = 1'b1; p1ok = 1'b1;
    tick();
    clear_answers();
    check("s1_judg1", {14'd0, judg1_w[0]}, 16'h1);
    check("s1_judg2", {14'd0, judg2_w[0]}, 16'h2);
    check("s1_que_low", {15'd0, que_w[0]}, 16'd0);
    abort_to_idle();

    // P2 wrong in cycle 2, P2 retries while locked, P1 wrong in cycle 5.
    start_round();
    tick();
    p2v = 1'b1; p2ok = 1'b0;
    tick();
    clear_answers();
    check("s2_wrong2", {14'd0, wrong1_w[0], wrong2_w[0]}, 16'b01);
    tick();
    p2v = 1'b1; p2ok = 1'b1;
    tick();
    clear_answers();
    check("s2_locked_ignored", {13'd0, state_w[0]}, 16'(S_ANSWER));
    p1v = 1'b1; p1ok = 1'b0;
    tick();
    clear_answers();
    check("s2_wrong1", {15'd0, wrong1_w[0]}, 16'd1);
    check("s2_void", {12'd0, judg1_w[0], judg2_w[0]}, 16'hF);
    abort_to_idle();

    // Silent round: the 8-cycle window closes, the 20-cycle one is aborted.
    start_round();
    repeat (7) tick();
    check("s3_still_answer", {13'd0, state_w[1]}, 16'(S_ANSWER));
    tick();
    check("s3_timeout_state", {13'd0, state_w[1]}, 16'(S_JUDGE));
    check("s3_timeout_void", {12'd0, judg1_w[1], judg2_w[1]}, 16'hF);
    ready = 1'b0;
    tick();
    check("s3_abort_idle", {13'd0, state_w[0]}, 16'(S_IDLE));
    check("s3_abort_nojudg", {12'd0, judg1_w[0], judg2_w[0]}, 16'h0);
    tick();

    // Reset in the middle of an answer window with a WRONG pulse showing.
    start_round();
    tick();
    p1v = 1'b1; p1ok = 1'b0;
    tick();
    clear_answers();
    check("s4_wrong1", {15'd0, wrong1_w[0]}, 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s4_rst_dut0", dut_out(0), 16'h0000);
    check("s4_rst_dut1", dut_out(1), 16'h0000);

    // Two double-correct rounds: P1 first (post-reset priority), then P2.
    start_round();
    p1v = 1'b1; p1ok = 1'b1; p2v = 1'b1; p2ok = 1'b1;
    tick();
    clear_answers();
    check("s5_r1_p1_wins", {12'd0, judg1_w[0], judg2_w[0]}, 16'h6);
    start_round();
    p1v = 1'b1; p1ok = 1'b1; p2v = 1'b1; p2ok = 1'b1;
    tick();
    clear_answers();
    check("s5_r2_p2_wins", {12'd0, judg1_w[0], judg2_w[0]}, 16'h9);

    // P2 out of HP during cooldown ends the game in P1's favour.
    tick();
    hp2 = 1'b1;
    wait_state(0, S_OVER, 20);
    check("s6_winner", {14'd0, winner_w[0]}, 16'h1);
    ready = 1'b0;
    tick();
    hp2 = 1'b0;
    check("s6_idle", {13'd0, state_w[0]}, 16'(S_IDLE));

    // Correct and wrong in the same cycle: correct one wins, the other gets WRONG.
    start_round();
    p1v = 1'b1; p1ok = 1'b0; p2v = 1'b1; p2ok = 1'b1;
    tick();
    clear_answers();
    check("s7_p2_wins", {12'd0, judg1_w[0], judg2_w[0]}, 16'h9);
    check("s7_wrong1", {14'd0, wrong1_w[0], wrong2_w[0]}, 16'b10);
    abort_to_idle();

    chk_en = 1'b0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/round_arbiter.md
ROUND_ARBITER -- requirements
Module: round_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1000, answer-window length in CLK cycles (1..65535).
REQ-002 SHALL have parameter GAP_CYC, default 16, cooldown cycles between rounds (1..255).
REQ-003 CLK  in  1  single system clock; all logic on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 READY_IN  in  1  level; both players ready, starts a game.
REQ-006 QUE_RDY  in  1  pulse; question generator has a new problem loaded.
REQ-007 P1_VALID / P2_VALID  in  1 each  pulse; player submitted an answer.
REQ-008 P1_OK / P2_OK  in  1 each  qualifies VALID; 1 = correct factorization.
REQ-009 HP1_ZERO / HP2_ZERO  in  1 each  level from HP manager; player HP exhausted.
REQ-010 QUE_REQ  out  1  one-cycle pulse requesting a new problem.
REQ-011 QUE  out  1  level; answer window open.
REQ-012 JUDG1 / JUDG2  out  2 each  one-cycle result code per player: 00 none, 01 self solved, 10 opponent solved, 11 void round.
REQ-013 WRONG1 / WRONG2  out  1 each  one-cycle pulse on a wrong answer.
REQ-014 STATE  out  3  current FSM state encoding.
REQ-015 WINNER  out  2  00 none, 01 P1, 10 P2, 11 draw; valid in GAMEOVER.

Function
REQ-016 FSM states SHALL be IDLE=0, REQ=1, WAITQ=2, ANSWER=3, JUDGE=4, GAP=5, GAMEOVER=6.
REQ-017 IDLE->REQ when READY_IN=1; REQ SHALL last exactly one cycle with QUE_REQ=1, then WAITQ.
REQ-018 WAITQ->ANSWER on QUE_RDY; QUE SHALL be 1 from the first ANSWER cycle, timer loaded with TIMEOUT_CYC-1.
REQ-019 In ANSWER, a VALID with OK=0 SHALL pulse that player's WRONG the next cycle and lock that player out for the round; later VALIDs from a locked player SHALL be ignored.
REQ-020 In ANSWER, first VALID with OK=1 from an unlocked player SHALL move to JUDGE; winner gets 01, other gets 10.
REQ-021 Both players correct in same cycle: winner SHALL be the player who did not win the previous scored round (P1 after reset); one correct + one wrong same cycle: correct wins, WRONG pulses for the other.
REQ-022 Both locked out, or timer reaching 0 with no winner, SHALL go to JUDGE with JUDG1=JUDG2=11.
REQ-023 JUDGE SHALL last one cycle, JUDG codes valid exactly in that cycle, QUE=0; latency from winning VALID to JUDG = 1 cycle.
REQ-024 GAP SHALL last GAP_CYC cycles, then REQ, unless HP1_ZERO or HP2_ZERO is 1 on the last GAP cycle, then GAMEOVER.
REQ-025 WINNER SHALL be 10 if only HP1_ZERO, 01 if only HP2_ZERO, 11 if both.
REQ-026 GAMEOVER SHALL hold until READY_IN falls, then IDLE.
REQ-027 READY_IN falling in any state except GAMEOVER SHALL abort to IDLE next cycle, QUE=0, no JUDG pulse.
REQ-028 QUE_RDY outside WAITQ and VALID outside ANSWER SHALL be ignored.

Reset
REQ-029 RST SHALL force IDLE, all outputs 0, lockouts cleared, priority to P1, timers cleared, including mid-round.

Structure
REQ-030 State encodings, JUDG codes and WINNER codes SHALL live in shared package game_pkg.
REQ-031 Tie-break and lockout logic SHALL be sub-module answer_arb; timers stay in round_arbiter.

Verification
REQ-032 READY_IN=1, QUE_RDY 3 cycles after QUE_REQ, P1_VALID+P1_OK at cycle 10 of ANSWER -> JUDG1=01, JUDG2=10 one cycle later, QUE falls.
REQ-033 P2 wrong at cycle 2, P1 wrong at cycle 5 -> WRONG2 then WRONG1 pulses, JUDG1=JUDG2=11 next cycle.
REQ-034 TIMEOUT_CYC=8, no answers -> JUDGE after exactly 8 ANSWER cycles, codes 11.
REQ-035 Both correct same cycle twice in a row -> first round P1 wins, second P2 wins.
REQ-036 HP2_ZERO=1 during GAP -> GAMEOVER, WINNER=01; READY_IN=0 -> IDLE.
REQ-037 RST asserted in ANSWER -> next cycle STATE=0, all outputs 0.
